// File: rtl/framebuffer_pio_pkg.sv
// Shared constants for the framebuffer Avalon-MM PIO pair (data output and status input).
package framebuffer_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/fb_sync_edge_detect.sv
// Synchronizes the asynchronous status bus and produces a per-bit edge vector,
// held off after reset until the synchronizer has filled with real samples.
module fb_sync_edge_detect
  import framebuffer_pio_pkg::*;
#(
  parameter int DATA_WIDTH  = 19,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i_in,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [DATA_WIDTH-1:0] o_edge
);

  localparam int CW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] PRIME_MAX = CW'(SYNC_STAGES + 1);
  localparam logic [CW-1:0] PRIME_ONE = CW'(1);

  logic [DATA_WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] r_prev;
  logic [CW-1:0]         r_prime;
  logic [DATA_WIDTH-1:0] w_cur;
  logic [DATA_WIDTH-1:0] w_edge_raw;

  assign w_cur  = r_sync[SYNC_STAGES-1];
  assign o_data = w_cur;

  // Synchronizer chain, previous sample and saturating prime counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
      r_prev  <= '0;
      r_prime <= '0;
    end else begin
      r_sync[0] <= i_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= w_cur;
      if (r_prime != PRIME_MAX) begin
        r_prime <= r_prime + PRIME_ONE;
      end else begin
        r_prime <= r_prime;
      end
    end
  end

  // Edge selection; suppressed until the prime window has elapsed.
  always_comb begin
    w_edge_raw = '0;
    case (EDGE_TYPE)
      EDGE_RISE: w_edge_raw = w_cur & ~r_prev;
      EDGE_FALL: w_edge_raw = ~w_cur & r_prev;
      EDGE_ANY:  w_edge_raw = w_cur ^ r_prev;
      default:   w_edge_raw = w_cur ^ r_prev;
    endcase
    if (r_prime == PRIME_MAX) begin
      o_edge = w_edge_raw;
    end else begin
      o_edge = '0;
    end
  end

endmodule

// File: rtl/de2_115_qsys_framebuffer_status.sv
// Avalon-MM input PIO for framebuffer status: data/irqmask/edgecapture registers,
// registered read mux and level interrupt to the Nios II.
module de2_115_qsys_framebuffer_status
  import framebuffer_pio_pkg::*;
#(
  parameter int          DATA_WIDTH  = 19,
  parameter int          EDGE_TYPE   = 0,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] RESET_MASK  = 32'd0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] w_data_in;
  logic [DATA_WIDTH-1:0] w_edge;
  logic [DATA_WIDTH-1:0] w_clear;
  logic [DATA_WIDTH-1:0] w_capture_next;
  logic [DATA_WIDTH-1:0] w_mask_next;
  logic [31:0]           w_rd_next;
  logic                  w_wr;
  logic                  w_unused_wdata;

  logic [DATA_WIDTH-1:0] r_irq_mask;
  logic [DATA_WIDTH-1:0] r_edge_capture;

  assign w_wr           = chipselect & ~write_n;
  assign w_unused_wdata = ^writedata;

  fb_sync_edge_detect #(
    .DATA_WIDTH (DATA_WIDTH),
    .EDGE_TYPE  (EDGE_TYPE),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk   (clk),
    .reset (reset),
    .i_in  (in_port),
    .o_data(w_data_in),
    .o_edge(w_edge)
  );

  // Next-state of capture and mask; a same-cycle edge beats the clear.
  always_comb begin
    w_clear     = '0;
    w_mask_next = r_irq_mask;
    if (w_wr && (address == ADDR_EDGE)) begin
      w_clear = writedata[DATA_WIDTH-1:0];
    end else begin
      w_clear = '0;
    end
    if (w_wr && (address == ADDR_MASK)) begin
      w_mask_next = writedata[DATA_WIDTH-1:0];
    end else begin
      w_mask_next = r_irq_mask;
    end
    w_capture_next = (r_edge_capture & ~w_clear) | w_edge;
  end

  // Read mux; unqualified by chipselect so latency is always one cycle.
  always_comb begin
    w_rd_next = 32'd0;
    case (address)
      ADDR_DATA: w_rd_next[DATA_WIDTH-1:0] = w_data_in;
      ADDR_RSVD: w_rd_next = 32'd0;
      ADDR_MASK: w_rd_next[DATA_WIDTH-1:0] = r_irq_mask;
      ADDR_EDGE: w_rd_next[DATA_WIDTH-1:0] = r_edge_capture;
      default:   w_rd_next = 32'd0;
    endcase
  end

  // Register file, read data and interrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_mask     <= RESET_MASK[DATA_WIDTH-1:0];
      r_edge_capture <= '0;
      readdata       <= 32'd0;
      irq            <= 1'b0;
    end else begin
      r_irq_mask     <= w_mask_next;
      r_edge_capture <= w_capture_next;
      readdata       <= w_rd_next;
      irq            <= |(w_capture_next & w_mask_next);
    end
  end

endmodule

// File: tb/tb_de2_115_qsys_framebuffer_status.sv
// Randomized scoreboard bench for the framebuffer status PIO: two instances (rising/2-stage
// and falling/3-stage) checked against a history-based reference model every cycle.
module tb_de2_115_qsys_framebuffer_status;

  localparam int DW   = 19;
  localparam int NCYC = 4000;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [DW-1:0] in_port;
  logic [31:0]   rd0, rd1;
  logic          irq0, irq1;

  always #5 clk = ~clk;

  de2_115_qsys_framebuffer_status #(
    .DATA_WIDTH(DW), .EDGE_TYPE(0), .SYNC_STAGES(2), .RESET_MASK(32'd0)
  ) dut0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd0), .irq(irq0)
  );

  de2_115_qsys_framebuffer_status #(
    .DATA_WIDTH(DW), .EDGE_TYPE(1), .SYNC_STAGES(3), .RESET_MASK(32'h0000_0005)
  ) dut1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd1), .irq(irq1)
  );

  int total = 0;
  int bad   = 0;
  logic [32:0] q0[$];
  logic [32:0] q1[$];

  // Reference model state: input history per clock edge, last reset edge, capture and mask.
  logic [DW-1:0] hist [NCYC+16];
  int            r_last = 0;
  logic [DW-1:0] cap  [2];
  logic [DW-1:0] mask [2];

  function automatic int stages(int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic logic [DW-1:0] rmask(int k);
    return (k == 0) ? 19'h00000 : 19'h00005;
  endfunction

  // Synchronized value seen after edge j was sampled at edge j-S+1; nothing before reset survives.
  function automatic logic [DW-1:0] val(int j);
    if (j < 0 || j <= r_last) return '0;
    return hist[j];
  endfunction

  // Model of edge n using the inputs that were stable before it.
  task automatic model_step(input int n);
    logic [DW-1:0] cur, prv, ev, clr;
    logic [31:0]   rd;
    logic          ir;
    int            s;
    hist[n] = in_port;
    if (reset) r_last = n;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        cap[k]  = '0;
        mask[k] = rmask(k);
        rd      = 32'd0;
        ir      = 1'b0;
      end else begin
        s   = stages(k);
        cur = val(n - s);
        prv = val(n - s - 1);
        ev  = '0;
        if (n >= r_last + s + 2) ev = (k == 0) ? (cur & ~prv) : (~cur & prv);
        case (address)
          2'd0:    rd = {13'd0, cur};
          2'd2:    rd = {13'd0, mask[k]};
          2'd3:    rd = {13'd0, cap[k]};
          default: rd = 32'd0;
        endcase
        clr = (chipselect && !write_n && address == 2'd3) ? writedata[DW-1:0] : '0;
        cap[k] = (cap[k] & ~clr) | ev;
        if (chipselect && !write_n && address == 2'd2) mask[k] = writedata[DW-1:0];
        ir = |(cap[k] & mask[k]);
      end
      if (k == 0) q0.push_back({ir, rd});
      else        q1.push_back({ir, rd});
    end
  endtask

  // Monitor: outputs are presented every cycle; compare away from the active edge.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        total++;
        if (rd0 !== e[31:0]) begin
          bad++;
          $display("FAIL rd_rise t=%0t got=%h exp=%h", $time, rd0, e[31:0]);
        end
        total++;
        if (irq0 !== e[32]) begin
          bad++;
          $display("FAIL irq_rise t=%0t got=%b exp=%b", $time, irq0, e[32]);
        end
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        total++;
        if (rd1 !== e[31:0]) begin
          bad++;
          $display("FAIL rd_fall t=%0t got=%h exp=%h", $time, rd1, e[31:0]);
        end
        total++;
        if (irq1 !== e[32]) begin
          bad++;
          $display("FAIL irq_fall t=%0t got=%b exp=%b", $time, irq1, e[32]);
        end
      end
    end
  end

  // Driver: directed prologue (reset with inputs high), then randomized bus traffic.
  initial begin
    logic [DW-1:0] flip;
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    in_port    = 19'h7FFFF;
    for (int n = 0; n < NCYC; n++) begin
      @(posedge clk);
      #1;
      model_step(n);
      if (n < 12) begin
        reset      = (n < 1);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = (n % 2 == 0) ? 2'd0 : 2'd3;
      end else if (n < 20) begin
        reset      = 1'b0;
        chipselect = 1'b1;
        write_n    = (n == 12) ? 1'b0 : 1'b1;
        address    = (n == 12) ? 2'd2 : 2'd3;
        writedata  = 32'h0000_0021;
        in_port    = 19'h7FFDE;
      end else begin
        reset      = (n == 1500) || (n == 2500) || ($urandom_range(0, 299) == 0);
        chipselect = ($urandom_range(0, 3) != 0);
        write_n    = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
        address    = 2'($urandom_range(0, 3));
        writedata  = $urandom;
        if (address == 2'd2 && $urandom_range(0, 3) == 0) writedata = 32'd0;
        flip       = 19'($urandom & $urandom & $urandom);
        in_port    = in_port ^ flip;
      end
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL drain q0=%0d q1=%0d exp=0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
